// File: rtl/uart_io_ctrl_if.sv
// Memory-stage bus between the CPU and the UART I/O sequencer,
// including the RX/TX FIFO handshake lines.
interface uart_io_ctrl_if;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic        writectrl;
    logic        memread;
    logic        rx_empty;
    logic [7:0]  rx_q;
    logic        tx_full;
    logic        rx_rdreq;
    logic        tx_wrreq;
    logic [7:0]  tx_data;
    logic        stall;
    logic [31:0] io_readdata;
    logic        io_valid;

    modport master (
        output addr, writedata, writectrl, memread,
        output rx_empty, rx_q, tx_full,
        input  rx_rdreq, tx_wrreq, tx_data,
        input  stall, io_readdata, io_valid
    );

    modport slave (
        input  addr, writedata, writectrl, memread,
        input  rx_empty, rx_q, tx_full,
        output rx_rdreq, tx_wrreq, tx_data,
        output stall, io_readdata, io_valid
    );
endinterface

// File: rtl/uart_io_ctrl.sv
// Sequences memory-stage loads/stores onto the UART FIFOs,
// stalling the pipeline and keeping a saturating stall counter.
module uart_io_ctrl #(
    parameter logic [31:0] UART_DATA_ADDR = 32'h0000_0004,
    parameter logic [31:0] UART_STAT_ADDR = 32'h0000_0008
) (
    input logic           clk,
    input logic           rst,
    uart_io_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        RX_WAIT,
        RX_READ,
        RX_DONE,
        TX_WAIT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  rd_byte;
    logic [15:0] stall_cnt;

    logic        rd_data;
    logic        wr_data;
    logic        rd_stat;
    logic        wr_stat;
    logic        stat_clr;

    logic        rx_rdreq;
    logic        tx_wrreq;
    logic        stall;
    logic        io_valid;
    logic [31:0] io_readdata;

    assign rd_data = bus.memread   & (bus.addr == UART_DATA_ADDR);
    assign wr_data = bus.writectrl & (bus.addr == UART_DATA_ADDR);
    assign rd_stat = bus.memread   & (bus.addr == UART_STAT_ADDR);
    assign wr_stat = bus.writectrl & (bus.addr == UART_STAT_ADDR);

    // RX_DONE does not re-decode the (still held) request inputs
    assign stat_clr = wr_stat & (state != RX_DONE);

    always_comb begin
        rx_rdreq    = 1'b0;
        tx_wrreq    = 1'b0;
        stall       = 1'b0;
        io_valid    = 1'b0;
        io_readdata = 32'h0;
        state_nxt   = state;
        // reset forces every strobe low even if a request is held
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (rd_data) begin
                        stall = 1'b1;
                        if (!bus.rx_empty) begin
                            rx_rdreq  = 1'b1;
                            state_nxt = RX_READ;
                        end else begin
                            state_nxt = RX_WAIT;
                        end
                    end else if (wr_data) begin
                        if (!bus.tx_full) begin
                            tx_wrreq = 1'b1;
                        end else begin
                            stall     = 1'b1;
                            state_nxt = TX_WAIT;
                        end
                    end else if (rd_stat) begin
                        io_valid    = 1'b1;
                        io_readdata = {stall_cnt, 14'b0,
                                       bus.tx_full, ~bus.rx_empty};
                    end
                end
                RX_WAIT: begin
                    stall = 1'b1;
                    if (!bus.rx_empty) begin
                        rx_rdreq  = 1'b1;
                        state_nxt = RX_READ;
                    end
                end
                RX_READ: begin
                    stall     = 1'b1;
                    state_nxt = RX_DONE;
                end
                RX_DONE: begin
                    io_valid    = 1'b1;
                    io_readdata = {24'b0, rd_byte};
                    state_nxt   = IDLE;
                end
                TX_WAIT: begin
                    if (!bus.tx_full) begin
                        tx_wrreq  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.rx_rdreq    = rx_rdreq;
    assign bus.tx_wrreq    = tx_wrreq;
    assign bus.stall       = stall;
    assign bus.io_valid    = io_valid;
    assign bus.io_readdata = io_readdata;
    assign bus.tx_data     = bus.writedata[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_byte   <= 8'h0;
            stall_cnt <= 16'h0;
        end else begin
            state <= state_nxt;
            if (state == RX_READ) begin
                rd_byte <= bus.rx_q;
            end
            if (stat_clr) begin
                stall_cnt <= 16'h0;
            end else if (stall && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'h1;
            end
        end
    end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed-vector bench for uart_io_ctrl: loads, stores, status,
// reset mid-access and stall counter saturation.
module tb_uart_io_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;
    logic [3:0] f;

    uart_io_ctrl_if bus();

    uart_io_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {rx_rdreq, tx_wrreq, stall, io_valid}
    function automatic logic [3:0] flags();
        return {bus.rx_rdreq, bus.tx_wrreq, bus.stall, bus.io_valid};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.memread   = 1'b0;
        bus.writectrl = 1'b0;
        bus.addr      = 32'h0;
    endtask

    task automatic load(input logic [31:0] a);
        bus.writectrl = 1'b0;
        bus.memread   = 1'b1;
        bus.addr      = a;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.memread   = 1'b0;
        bus.writectrl = 1'b1;
        bus.addr      = a;
        bus.writedata = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.writedata = 32'h0000_00AB;
        bus.rx_empty  = 1'b0;
        bus.tx_full   = 1'b0;
        bus.rx_q      = 8'h00;
        load(32'h4);
        @(negedge clk);
        f = flags();
        total++;
        if (f !== 4'b0000)
            $display("FAIL rst_flags: got %b want 0000", f);
        else passed++;
        total++;
        if (bus.io_readdata !== 32'h0)
            $display("FAIL rst_rdata: got %h want 0", bus.io_readdata);
        else passed++;
        total++;
        if (bus.tx_data !== 8'hAB)
            $display("FAIL rst_txdata: got %h want ab", bus.tx_data);
        else passed++;
        tick();
        rst = 1'b0;
        idle();
        bus.rx_empty = 1'b1;
        tick();
    endtask

    task automatic test_rx_load();
        load(32'h4);
        bus.rx_empty = 1'b0;
        @(negedge clk);
        f = flags();
        total++;
        if (f !== 4'b1010)
            $display("FAIL ld_c1: got %b want 1010", f);
        else passed++;
        tick();
        bus.rx_empty = 1'b1;
        bus.rx_q     = 8'h5A;
        @(negedge clk);
        f = flags();
        total++;
        if (f !== 4'b0010)
            $display("FAIL ld_c2: got %b want 0010", f);
        else passed++;
        tick();
        bus.rx_q = 8'h00;
        @(negedge clk);
        f = flags();
        total++;
        if (f !== 4'b0001 || bus.io_readdata !== 32'h0000_005A)
            $display("FAIL ld_c3: got %b/%h want 0001/0000005a",
                     f, bus.io_readdata);
        else passed++;
        tick();
        idle();
        @(negedge clk);
        f = flags();
        total++;
        if (f !== 4'b0000 || bus.io_readdata !== 32'h0)
            $display("FAIL ld_idle: got %b/%h want 0000/0",
                     f, bus.io_readdata);
        else passed++;
        tick();
    endtask

    task automatic test_rx_wait_status();
        store(32'h8, 32'h0);
        tick();
        load(32'h4);
        bus.rx_empty = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            f = flags();
            total++;
            if (f !== 4'b0010)
                $display("FAIL wait_c%0d: got %b want 0010", i + 1, f);
            else passed++;
            tick();
        end
        bus.rx_empty = 1'b0;
        @(negedge clk);
        f = flags();
        total++;
        if (f !== 4'b1010)
            $display("FAIL wait_pop: got %b want 1010", f);
        else passed++;
        tick();
        bus.rx_empty = 1'b1;
        bus.rx_q     = 8'hC3;
        tick();
        @(negedge clk);
        f = flags();
        total++;
        if (f !== 4'b0001 || bus.io_readdata !== 32'h0000_00C3)
            $display("FAIL wait_done: got %b/%h want 0001/000000c3",
                     f, bus.io_readdata);
        else passed++;
        tick();
        load(32'h8);
        bus.tx_full  = 1'b1;
        bus.rx_empty = 1'b0;
        @(negedge clk);
        f = flags();
        total++;
        if (f !== 4'b0001 || bus.io_readdata !== 32'h0007_0003)
            $display("FAIL stat_rd: got %b/%h want 0001/00070003",
                     f, bus.io_readdata);
        else passed++;
        tick();
        store(32'h8, 32'h0);
        @(negedge clk);
        f = flags();
        total++;
        if (f !== 4'b0000)
            $display("FAIL stat_clr: got %b want 0000", f);
        else passed++;
        tick();
        load(32'h8);
        @(negedge clk);
        total++;
        if (bus.io_readdata !== 32'h0000_0003)
            $display("FAIL stat_after_clr: got %h want 00000003",
                     bus.io_readdata);
        else passed++;
        tick();
        bus.tx_full  = 1'b0;
        bus.rx_empty = 1'b1;
        idle();
    endtask

    task automatic test_tx_store();
        store(32'h4, 32'h1234_5641);
        @(negedge clk);
        f = flags();
        total++;
        if (f !== 4'b0100 || bus.tx_data !== 8'h41)
            $display("FAIL st_fast: got %b/%h want 0100/41",
                     f, bus.tx_data);
        else passed++;
        tick();
        bus.tx_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            f = flags();
            total++;
            if (f !== 4'b0010)
                $display("FAIL st_full_c%0d: got %b want 0010", i + 1, f);
            else passed++;
            tick();
        end
        bus.tx_full = 1'b0;
        @(negedge clk);
        f = flags();
        total++;
        if (f !== 4'b0100 || bus.tx_data !== 8'h41)
            $display("FAIL st_push: got %b/%h want 0100/41",
                     f, bus.tx_data);
        else passed++;
        tick();
        load(32'h10);
        @(negedge clk);
        f = flags();
        total++;
        if (f !== 4'b0000 || bus.io_readdata !== 32'h0)
            $display("FAIL other_addr: got %b/%h want 0000/0",
                     f, bus.io_readdata);
        else passed++;
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        load(32'h4);
        bus.rx_empty = 1'b0;
        tick();
        bus.rx_empty = 1'b1;
        bus.rx_q     = 8'h11;
        tick();
        bus.rx_empty = 1'b0;
        @(negedge clk);
        total++;
        if (bus.io_readdata !== 32'h11 || bus.rx_rdreq !== 1'b0)
            $display("FAIL b2b_first: got %h/%b want 11/0",
                     bus.io_readdata, bus.rx_rdreq);
        else passed++;
        tick();
        @(negedge clk);
        f = flags();
        total++;
        if (f !== 4'b1010)
            $display("FAIL b2b_second_pop: got %b want 1010", f);
        else passed++;
        tick();
        bus.rx_empty = 1'b1;
        bus.rx_q     = 8'h22;
        tick();
        @(negedge clk);
        total++;
        if (bus.io_readdata !== 32'h22 || bus.io_valid !== 1'b1)
            $display("FAIL b2b_second: got %h/%b want 22/1",
                     bus.io_readdata, bus.io_valid);
        else passed++;
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        load(32'h4);
        bus.rx_empty = 1'b0;
        tick();
        bus.rx_q = 8'hEE;
        rst      = 1'b1;
        #1;
        f = flags();
        total++;
        if (f !== 4'b0000 || bus.io_readdata !== 32'h0)
            $display("FAIL mid_rst: got %b/%h want 0000/0",
                     f, bus.io_readdata);
        else passed++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        f = flags();
        total++;
        if (f !== 4'b1010)
            $display("FAIL mid_repop: got %b want 1010", f);
        else passed++;
        tick();
        bus.rx_empty = 1'b1;
        bus.rx_q     = 8'h77;
        tick();
        @(negedge clk);
        total++;
        if (bus.io_readdata !== 32'h77)
            $display("FAIL mid_data: got %h want 00000077",
                     bus.io_readdata);
        else passed++;
        tick();
        load(32'h8);
        @(negedge clk);
        total++;
        if (bus.io_readdata !== 32'h0002_0000)
            $display("FAIL mid_cnt: got %h want 00020000",
                     bus.io_readdata);
        else passed++;
        tick();
        idle();
    endtask

    task automatic test_saturate();
        load(32'h4);
        bus.rx_empty = 1'b1;
        tick();
        repeat (70000) tick();
        bus.rx_empty = 1'b0;
        @(negedge clk);
        f = flags();
        total++;
        if (f !== 4'b1010)
            $display("FAIL sat_pop: got %b want 1010", f);
        else passed++;
        tick();
        bus.rx_empty = 1'b1;
        bus.rx_q     = 8'h9E;
        tick();
        tick();
        load(32'h8);
        @(negedge clk);
        total++;
        if (bus.io_readdata !== 32'hFFFF_0000)
            $display("FAIL sat_cnt: got %h want ffff0000",
                     bus.io_readdata);
        else passed++;
        tick();
        store(32'h8, 32'h0);
        tick();
        load(32'h4);
        tick();
        store(32'h8, 32'h0);
        @(negedge clk);
        f = flags();
        total++;
        if (f !== 4'b0010)
            $display("FAIL clr_win_stall: got %b want 0010", f);
        else passed++;
        tick();
        load(32'h4);
        bus.rx_empty = 1'b0;
        tick();
        bus.rx_empty = 1'b1;
        bus.rx_q     = 8'h3C;
        tick();
        @(negedge clk);
        total++;
        if (bus.io_readdata !== 32'h3C)
            $display("FAIL clr_win_data: got %h want 0000003c",
                     bus.io_readdata);
        else passed++;
        tick();
        load(32'h8);
        @(negedge clk);
        total++;
        if (bus.io_readdata !== 32'h0002_0000)
            $display("FAIL clr_win_cnt: got %h want 00020000",
                     bus.io_readdata);
        else passed++;
        tick();
        idle();
    endtask

    initial begin
        test_reset();
        test_rx_load();
        test_rx_wait_status();
        test_tx_store();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
